// File: rtl/stoch_cross_prod_array_pkg.sv
// Shared constants for the stochastic cross-product array.
// Holds component indices, vector length and the counter ceiling helper.
package stoch_cross_prod_array_pkg;

   localparam int IDX_X = 0;
   localparam int IDX_Y = 1;
   localparam int IDX_Z = 2;
   localparam int VEC3  = 3;

   // Largest value a debt counter of width w can hold.
   function automatic int cmax_of(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/stoch_sat_sub_cnt.sv
// Counter-based saturating bitstream subtractor (y ~ a - b, clipped at 0).
// Ports: CLK, RST (async high), en, clr, a, b -> y, sat (sticky ceiling hit).
import stoch_cross_prod_array_pkg::*;

module stoch_sat_sub_cnt #(
   parameter int CNT_WIDTH = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic clr,
   input  logic a,
   input  logic b,
   output logic y,
   output logic sat
);

   localparam logic [CNT_WIDTH-1:0] CMAX =
      CNT_WIDTH'(cmax_of(CNT_WIDTH));
   localparam logic [CNT_WIDTH-1:0] CMAX_M1 = CMAX - 1'b1;

   logic [CNT_WIDTH-1:0] c_q, c_d;
   logic                 sat_q, sat_d;
   logic                 y_c;

   // c holds the "debt" of b pulses not yet cancelled by a pulses.
   always_comb begin
      c_d   = c_q;
      sat_d = sat_q;
      y_c   = 1'b0;
      if (clr) begin
         c_d   = '0;
         sat_d = 1'b0;
      end else if (en) begin
         if (a && !b) begin
            if (c_q != '0) c_d = c_q - 1'b1;
            else           y_c = 1'b1;
         end else if (!a && b) begin
            // At the ceiling the excess b is dropped.
            if (c_q == CMAX) begin
               sat_d = 1'b1;
            end else begin
               c_d = c_q + 1'b1;
               if (c_q == CMAX_M1) sat_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c_q   <= '0;
         sat_q <= 1'b0;
      end else begin
         c_q   <= c_d;
         sat_q <= sat_d;
      end
   end

   // Output reads 0 while reset is held, even combinationally.
   assign y   = y_c & ~RST;
   assign sat = sat_q;

endmodule

// File: rtl/stoch_cross_prod_array.sv
// NUM_CH-channel stochastic 3D cross product u x v as split-sign bitstreams.
// Ports: CLK, RST, en, clr, u, v -> y_p, y_m, y_valid, sat_flag.
import stoch_cross_prod_array_pkg::*;

module stoch_cross_prod_array #(
   parameter int NUM_CH    = 1,
   parameter int CNT_WIDTH = 4,
   parameter int OUT_REG   = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   en,
   input  logic                   clr,
   input  logic [3*NUM_CH-1:0]    u,
   input  logic [3*NUM_CH-1:0]    v,
   output logic [3*NUM_CH-1:0]    y_p,
   output logic [3*NUM_CH-1:0]    y_m,
   output logic                   y_valid,
   output logic [NUM_CH-1:0]      sat_flag
);

   localparam int W = VEC3 * NUM_CH;

   logic [W-1:0] m1, m2;
   logic [W-1:0] yp_c, ym_c;
   logic [W-1:0] sat_p, sat_m;
   logic         valid_c;

   assign valid_c = en & ~clr & ~RST;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam int B = VEC3 * k;

      assign m1[B+IDX_X] = u[B+IDX_Y] & v[B+IDX_Z];
      assign m2[B+IDX_X] = u[B+IDX_Z] & v[B+IDX_Y];
      assign m1[B+IDX_Y] = u[B+IDX_Z] & v[B+IDX_X];
      assign m2[B+IDX_Y] = u[B+IDX_X] & v[B+IDX_Z];
      assign m1[B+IDX_Z] = u[B+IDX_X] & v[B+IDX_Y];
      assign m2[B+IDX_Z] = u[B+IDX_Y] & v[B+IDX_X];

      for (genvar i = 0; i < VEC3; i++) begin : g_cmp
         stoch_sat_sub_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_p (
            .CLK(CLK), .RST(RST), .en(en), .clr(clr),
            .a(m1[B+i]), .b(m2[B+i]),
            .y(yp_c[B+i]), .sat(sat_p[B+i])
         );
         stoch_sat_sub_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_m (
            .CLK(CLK), .RST(RST), .en(en), .clr(clr),
            .a(m2[B+i]), .b(m1[B+i]),
            .y(ym_c[B+i]), .sat(sat_m[B+i])
         );
      end

      assign sat_flag[k] = |{sat_p[B +: VEC3], sat_m[B +: VEC3]};
   end

   if (OUT_REG != 0) begin : g_oreg
      logic [W-1:0] y_p_q, y_m_q;
      logic         y_valid_q;

      // Loads every cycle; stall cycles load the zeros produced upstream.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            y_p_q     <= '0;
            y_m_q     <= '0;
            y_valid_q <= 1'b0;
         end else begin
            y_p_q     <= yp_c;
            y_m_q     <= ym_c;
            y_valid_q <= valid_c;
         end
      end

      assign y_p     = y_p_q;
      assign y_m     = y_m_q;
      assign y_valid = y_valid_q;
   end else begin : g_comb
      assign y_p     = yp_c;
      assign y_m     = ym_c;
      assign y_valid = valid_c;
   end

endmodule
